pic_row_scanner: RTL and testbench
==================================

PIC_ROW_SCANNER -- requirements
Module: pic_row_scanner

Interface
REQ-001 SHALL have parameter DWELL, default 1000: clocks each row is driven, legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port scan_en  input  1  high = scanning permitted (tied to Gaming/ready game states).
REQ-005 SHALL have port pic_load  input  1  one-clock strobe; pic_in is valid on that cycle.
REQ-006 SHALL have port pic_in  input  160  picture as 16 rows x 10 columns; row r = bits [159-10r : 150-10r].
REQ-007 SHALL have port row_sel  output  16  one-hot row drive, bit r = row r active.
REQ-008 SHALL have port col_data  output  10  column pattern of the active row, bit 9 = leftmost column.
REQ-009 SHALL have port frame_done  output  1  one-clock pulse at end of row 15 of each scanned frame.
REQ-010 SHALL have port pending  output  1  high while a loaded picture awaits frame-boundary swap.

Function
REQ-011 SHALL hold two 160-bit buffers: shadow (written by pic_load) and active (scanned).
REQ-012 SHALL, on pic_load, write pic_in to shadow and set pending next clock; a later pic_load before the swap overwrites shadow (last write wins).
REQ-013 SHALL implement states IDLE and SCAN (plus BLANK per REQ-027).
REQ-014 IDLE: row_sel=0, col_data=0; go to SCAN when scan_en=1 and pending=1, copying shadow to active, clearing pending, row=0, dwell counter=0.
REQ-015 SCAN: row_sel=1<<row, col_data=active row slice, both registered (one-clock latency from row/active change).
REQ-016 SHALL increment dwell counter each clock in SCAN; at DWELL-1, counter resets to 0 and row advances.
REQ-017 SHALL, on advance from row 15, pulse frame_done one clock, wrap row to 0, and swap shadow into active if pending (clearing pending) else rescan active unchanged.
REQ-018 SHALL give pic_load priority over a simultaneous swap: the swap takes the old shadow contents and pending stays set for the new picture.
REQ-019 SHALL, when scan_en falls in SCAN, go to IDLE next clock with row_sel=0, col_data=0, no frame_done; active is retained and pending is unchanged.
REQ-020 SHALL, on scan_en re-assertion from IDLE with pending=0 but a valid active frame, resume SCAN at row 0 with the retained active.
REQ-021 SHALL never drive more than one row_sel bit high in any cycle.
REQ-022 SHALL size the dwell counter to ceil(log2(DWELL)) bits and never let it exceed DWELL-1.

Reset
REQ-023 SHALL, on rst low, immediately clear row_sel, col_data, frame_done, pending, shadow, active, counters, the active-valid flag, and force IDLE.
REQ-024 SHALL abandon any in-progress frame on reset mid-scan, with no frame_done pulse.
REQ-025 SHALL leave IDLE after reset only per REQ-014.

Configuration
REQ-026 SHALL support macro PIC_SCAN_BLANK_EN.
REQ-027 With PIC_SCAN_BLANK_EN defined: state BLANK is inserted for exactly 2 clocks between consecutive rows (including row 15 to row 0), with row_sel=0 and col_data=0 (ghosting suppression); frame_done fires on entry to the BLANK after row 15.
REQ-028 Without PIC_SCAN_BLANK_EN: no BLANK state; rows change back-to-back, with frame period exactly 16*DWELL clocks.

Verification (DWELL=4)
REQ-029 Reset, scan_en=1, pic_load with row 0=10'h3FF, other rows 0 -> row_sel=16'h0001, col_data=10'h3FF for 4 clocks, then row_sel=16'h0002, col_data=0.
REQ-030 Free run without macro -> frame_done period 64 clocks; with macro -> 96 clocks, with row_sel=0 during 2-clock gaps.
REQ-031 Two pic_loads (A, then B) during a frame -> current frame unchanged; next frame shows B; pending falls the clock after the swap.
REQ-032 pic_load on the same clock as the row 15 -> row 0 swap -> old shadow is displayed; pending=1; the new picture is shown the following frame.
REQ-033 scan_en low at row 7 -> row_sel=0 next clock; re-raise -> scan restarts at row 0 with the same picture.
REQ-034 rst low at row 9 mid-dwell -> all outputs 0 asynchronously; no frame_done; IDLE until a new pic_load.

Source files
------------

// File: rtl/pic_row_scanner.sv
// Double-buffered 16x10 picture row scanner; outputs registered, one clock after state change, no backpressure.
// Define PIC_SCAN_BLANK_EN to insert a 2-clock blank (row_sel=0) between consecutive rows.
module pic_row_scanner #(
  parameter int unsigned DWELL = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scan_en,
  input  logic         pic_load,
  input  logic [159:0] pic_in,
  output logic [15:0]  row_sel,
  output logic [9:0]   col_data,
  output logic         frame_done,
  output logic         pending
);

  localparam int unsigned CW = $clog2(DWELL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
`ifdef PIC_SCAN_BLANK_EN
  localparam logic [1:0] ST_BLANK = 2'd2;
  localparam logic [CW-1:0] BLANK_LAST = CW'(1);
`endif

  logic [1:0]    state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [159:0]  shadow_q, shadow_d;
  logic [159:0]  active_q, active_d;
  logic          act_vld_q, act_vld_d;
  logic          pending_q, pending_d;
  logic          fd_q, fd_d;
  logic [15:0]   row_sel_q, row_sel_d;
  logic [9:0]    col_q, col_d;
  logic          swap;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    act_vld_d = act_vld_q;
    pending_d = pending_q;
    fd_d      = 1'b0;
    swap      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (scan_en && (pending_q || act_vld_q)) begin
          state_d = ST_SCAN;
          row_d   = 4'd0;
          cnt_d   = '0;
          swap    = pending_q;
        end
      end
      ST_SCAN: begin
        if (!scan_en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          row_d = row_q + 4'd1;
          // Frame boundary: the only point where a pending picture may go live
          if (row_q == 4'd15) begin
            fd_d = 1'b1;
            swap = pending_q;
          end
`ifdef PIC_SCAN_BLANK_EN
          state_d = ST_BLANK;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef PIC_SCAN_BLANK_EN
      ST_BLANK: begin
        if (!scan_en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (swap) begin
      active_d  = shadow_q;
      act_vld_d = 1'b1;
      pending_d = 1'b0;
    end
    // A load coinciding with a swap wins: the swap took the old shadow above
    if (pic_load) begin
      shadow_d  = pic_in;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    row_sel_d = '0;
    col_d     = '0;
    if (state_d == ST_SCAN) begin
      row_sel_d = 16'd1 << row_d;
      for (int r = 0; r < 16; r++) begin
        if (row_d == 4'(r)) col_d = active_d[159-10*r -: 10];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      row_q     <= 4'd0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      act_vld_q <= 1'b0;
      pending_q <= 1'b0;
      fd_q      <= 1'b0;
      row_sel_q <= '0;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      act_vld_q <= act_vld_d;
      pending_q <= pending_d;
      fd_q      <= fd_d;
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
    end
  end

  assign row_sel    = row_sel_q;
  assign col_data   = col_q;
  assign frame_done = fd_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_pic_row_scanner.sv
// Scoreboard bench for pic_row_scanner: frame-position reference model feeds an expectation queue, monitor compares.
module tb_pic_row_scanner;
  localparam int DWELL = 4;
`ifdef PIC_SCAN_BLANK_EN
  localparam int BL = 2;
`else
  localparam int BL = 0;
`endif
  localparam int RP = DWELL + BL;
  localparam int FP = 16 * RP;

  logic         clk = 1'b0;
  logic         rst, scan_en, pic_load;
  logic [159:0] pic_in;
  logic [15:0]  row_sel;
  logic [9:0]   col_data;
  logic         frame_done, pending;

  always #5 clk = ~clk;

  pic_row_scanner #(.DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .pic_load(pic_load), .pic_in(pic_in),
    .row_sel(row_sel), .col_data(col_data), .frame_done(frame_done), .pending(pending)
  );

  typedef struct {
    int          cyc;
    logic [15:0] rs;
    logic [9:0]  cd;
    logic        fd;
    logic        pd;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nprint = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: position within the frame, blanks trail each row
  bit           m_scan, m_pend, m_vld, m_fd;
  int           m_pos;
  logic [159:0] m_act, m_sh;

  function automatic void model_reset();
    m_scan = 0; m_pend = 0; m_vld = 0; m_fd = 0; m_pos = 0;
    m_act = '0; m_sh = '0;
  endfunction

  function automatic void model_step(bit se, bit ld, logic [159:0] p);
    bit swp;
    swp  = 0;
    m_fd = 0;
    if (!m_scan) begin
      if (se && (m_pend || m_vld)) begin
        m_scan = 1; m_pos = 0; swp = m_pend;
      end
    end else if (!se) begin
      m_scan = 0;
    end else begin
      m_pos = (m_pos + 1) % FP;
      if (m_pos == (FP - BL) % FP) begin
        m_fd = 1; swp = m_pend;
      end
    end
    if (swp) begin
      m_act = m_sh; m_pend = 0; m_vld = 1;
    end
    if (ld) begin
      m_sh = p; m_pend = 1;
    end
  endfunction

  function automatic exp_t model_out(int c);
    exp_t e;
    int   r;
    e.cyc = c; e.rs = '0; e.cd = '0; e.fd = m_fd; e.pd = m_pend;
    if (m_scan && (m_pos % RP) < DWELL) begin
      r    = m_pos / RP;
      e.rs = 16'd1 << r;
      e.cd = m_act[159-10*r -: 10];
    end
    return e;
  endfunction

  function automatic logic [159:0] rand_pic();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick(input bit r_n, input bit se, input bit ld, input logic [159:0] p);
    rst = r_n; scan_en = se; pic_load = ld; pic_in = p;
    if (!r_n) model_reset();
    else model_step(se, ld, p);
    exp_q.push_back(model_out(cyc + 1));
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1, 1, 0, '0);
  endtask

  task automatic run_to(input int target, input string name);
    int i;
    i = 0;
    while (!(m_scan && m_pos == target) && i < 2 * FP) begin
      tick(1, 1, 0, '0);
      i++;
    end
    checks++;
    if (!(m_scan && m_pos == target)) begin
      errors++;
      $display("FAIL %s: frame position %0d not reached, at %0d", name, target, m_pos);
    end
  endtask

  // Monitor: compare DUT outputs against queued expectations each cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (e.cyc != cyc || row_sel !== e.rs || col_data !== e.cd ||
            frame_done !== e.fd || pending !== e.pd) begin
          errors++;
          if (nprint < 40) begin
            nprint++;
            $display("FAIL scan cyc %0d (exp cyc %0d): got rs=%h cd=%h fd=%b pd=%b, want rs=%h cd=%h fd=%b pd=%b",
                     cyc, e.cyc, row_sel, col_data, frame_done, pending, e.rs, e.cd, e.fd, e.pd);
          end
        end
      end
    end
  end

  initial begin
    logic [159:0] p;
    rst = 1'b0; scan_en = 1'b0; pic_load = 1'b0; pic_in = '0;
    model_reset();
    @(posedge clk); #1;

    checks++;
    if (row_sel !== 16'h0 || col_data !== 10'h0 || frame_done !== 1'b0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rs=%h cd=%h fd=%b pd=%b, want all zero", row_sel, col_data, frame_done, pending);
    end
    for (int i = 0; i < 3; i++) tick(0, 1, 1, rand_pic());

    // Enabled with nothing loaded: must stay idle
    run(3);

    // Single lit row 0
    p = '0;
    p[159:150] = 10'h3FF;
    tick(1, 1, 1, p);
    run(2 * FP + 5);

    // Two loads within one frame: last one wins at the boundary
    run_to(3 * RP, "two_loads");
    tick(1, 1, 1, rand_pic());
    run(5);
    tick(1, 1, 1, rand_pic());
    run(2 * FP);

    // Load on the very clock of the frame swap
    run_to(FP - BL - 1, "load_at_swap");
    tick(1, 1, 1, rand_pic());
    run(2 * FP + 3);

    // Disable scanning at row 7, then resume
    run_to(7 * RP + 1, "row7_stop");
    for (int i = 0; i < 3; i++) tick(1, 0, 0, '0);
    run(FP + 10);

    // Asynchronous reset mid-dwell of row 9 with a picture pending
    run_to(8 * RP, "row8_load");
    tick(1, 1, 1, rand_pic());
    run_to(9 * RP + 2, "row9_reset");
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (row_sel !== 16'h0 || col_data !== 10'h0 || frame_done !== 1'b0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rs=%h cd=%h fd=%b pd=%b, want all zero", row_sel, col_data, frame_done, pending);
    end
    model_reset();
    tick(0, 1, 0, '0);
    tick(0, 1, 0, '0);
    run(12);
    tick(1, 1, 1, rand_pic());
    run(FP + 5);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      tick(1, $urandom_range(0, 99) < 97, $urandom_range(0, 99) < 4, rand_pic());
    end
    tick(1, 0, 0, '0);
    tick(1, 0, 0, '0);
    #5;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
